aud_transport_ctrl: RTL and testbench
=====================================

Name: aud_transport_ctrl

Overview:
Transport sequencer for the lab3 audio path. Turns key pulses (start/pause/stop) and a record/play mode bit into single-cycle control pulses for the I2S recorder and the DSP player. Owns the SRAM address/write-enable mux between those two requesters, latches the end-of-recording address, and keeps an elapsed-seconds count for the display.

Parameters:
ADDR_W, 20, SRAM word-address width
ADDR_MAX, 20'hFFFFF, last writable address; recording auto-stops here
SEC_TICKS, 32000, i_sample_tick pulses per elapsed second
SEC_W, 6, width of the seconds counter (saturates at 2^SEC_W-1)

Ports:
i_clk  in  1  system clock (BCLK domain)
i_rst  in  1  synchronous reset, active-high
i_key_start  in  1  one-cycle pulse: start or resume
i_key_pause  in  1  one-cycle pulse: pause
i_key_stop  in  1  one-cycle pulse: stop
i_mode  in  1  0 = record, 1 = play; sampled only in IDLE
i_sample_tick  in  1  one-cycle pulse per audio sample (LRC edge)
i_rec_addr  in  ADDR_W  recorder write address
i_rec_data  in  16  recorder write data
i_rec_wr  in  1  recorder write strobe
i_play_addr  in  ADDR_W  player read address
o_rec_start/o_rec_pause/o_rec_stop  out  1 each  one-cycle recorder control pulses
o_play_start/o_play_pause/o_play_stop  out  1 each  one-cycle player control pulses
o_sram_addr  out  ADDR_W  muxed SRAM address
o_sram_wdata  out  16  SRAM write data (= i_rec_data)
o_sram_we_n  out  1  SRAM write enable, active-low
o_end_addr  out  ADDR_W  one past last recorded word
o_state  out  3  IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4
o_seconds  out  SEC_W  elapsed seconds in the current session

Behaviour:
- Reset: state IDLE; all pulse outputs 0; o_sram_we_n=1; o_sram_addr=0; o_end_addr=0; o_seconds=0; tick counter 0. Reset mid-operation aborts with no stop pulses issued.
- Key priority in one cycle: stop > pause > start; lower-priority keys that cycle are dropped.
- IDLE + start: i_mode=0 -> REC, pulse o_rec_start, clear o_seconds and tick counter. i_mode=1 -> PLAY, pulse o_play_start, clear o_seconds; if o_end_addr==0, stay IDLE with no pulse.
- REC: pause -> REC_PAUSE + o_rec_pause; stop -> IDLE + o_rec_stop, o_end_addr <= i_rec_addr+1 if a write occurs that cycle, else i_rec_addr. Write with i_rec_addr==ADDR_MAX -> IDLE + o_rec_stop, o_end_addr <= ADDR_MAX (the write completes).
- REC_PAUSE: start -> REC + o_rec_start; stop -> IDLE + o_rec_stop, o_end_addr <= i_rec_addr.
- PLAY: pause -> PLAY_PAUSE + o_play_pause; stop -> IDLE + o_play_stop; i_play_addr >= o_end_addr -> IDLE + o_play_stop (end-of-data beats a same-cycle pause).
- PLAY_PAUSE: start -> PLAY + o_play_start; stop -> IDLE + o_play_stop.
- All control pulses registered: asserted exactly 1 cycle, in the cycle after the causing key.
- SRAM mux (combinational from registered state): REC/REC_PAUSE -> i_rec_addr; PLAY/PLAY_PAUSE -> i_play_addr; IDLE -> 0. o_sram_we_n = ~(state==REC & i_rec_wr); writes are blocked in every other state.
- Seconds: in REC or PLAY only, count i_sample_tick. At SEC_TICKS-1, wrap to 0 and increment o_seconds, saturating at all-ones. Pause freezes both counters. o_seconds holds its value in IDLE until the next start.
- i_mode changes outside IDLE are ignored.

Optional Feature:
LOOP_PLAY_EN: when defined, end-of-data in PLAY stays in PLAY, pulses o_play_stop then o_play_start on consecutive cycles (player restarts from 0), and clears o_seconds. When undefined, end-of-data returns to IDLE as above.

Test Plan:
- Reset -> o_state=0, o_sram_we_n=1, o_end_addr=0; assert i_rst during REC with i_rec_addr=100 -> next cycle IDLE, o_end_addr=0, no o_rec_stop.
- mode=0, start; 50 writes at addr 0..49; stop in the cycle after the last write -> o_rec_start 1 cycle, we_n low exactly 50 cycles, o_end_addr=50, state IDLE.
- Same cycle start+pause+stop in REC -> only o_rec_stop pulses, state IDLE.
- SEC_TICKS=4: 9 ticks in REC, pause, 4 ticks, start, 3 ticks -> o_seconds=3.
- Record with i_rec_addr stepping to ADDR_MAX while i_rec_wr=1 -> auto o_rec_stop, o_end_addr=ADDR_MAX, no writes after.
- o_end_addr=50, mode=1, start; drive i_play_addr to 50 -> o_play_stop, IDLE (with LOOP_PLAY_EN: stop then start pulses, stays PLAY, o_seconds=0); i_rec_wr=1 during PLAY -> we_n stays 1.

Source files
------------

// File: rtl/aud_transport_ctrl.sv
// ---------------------------------------------------------------------------
// aud_transport_ctrl
//
// Transport sequencer for the lab3 audio path. Key pulses (start / pause /
// stop) and a record/play mode bit become single-cycle control pulses for
// the I2S recorder and the DSP player. The block also owns the SRAM address
// and write-enable mux between those two requesters. It latches the
// end-of-recording address and keeps an elapsed-seconds count for the
// display.
//
// Optional feature macro: LOOP_PLAY_EN
//   When defined, reaching the end of recorded data during playback does
//   not return to IDLE. The block pulses o_play_stop and then o_play_start
//   on the next cycle, so the player restarts from address 0. It also
//   clears o_seconds. When undefined, end of data returns to IDLE.
//
// Parameters:
//   ADDR_W     SRAM word-address width
//   ADDR_MAX   last writable address; recording auto-stops here
//   SEC_TICKS  i_sample_tick pulses per elapsed second
//   SEC_W      width of the seconds counter (saturates at all-ones)
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_key_start         one-cycle start/resume key pulse
//   i_key_pause         one-cycle pause key pulse
//   i_key_stop          one-cycle stop key pulse
//   i_mode              0 = record, 1 = play (only looked at in IDLE)
//   i_sample_tick       one pulse per audio sample
//   i_rec_addr/data/wr  recorder write request
//   i_play_addr         player read address
//   o_rec_*             registered recorder control pulses
//   o_play_*            registered player control pulses
//   o_sram_addr         muxed SRAM address
//   o_sram_wdata        SRAM write data
//   o_sram_we_n         SRAM write enable, active-low
//   o_end_addr          one past the last recorded word
//   o_state             IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4
//   o_seconds           elapsed seconds in the current session
// ---------------------------------------------------------------------------
module aud_transport_ctrl #(
   parameter int                ADDR_W    = 20,
   parameter logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}},
   parameter int                SEC_TICKS = 32000,
   parameter int                SEC_W     = 6
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_key_start,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic              i_mode,
   input  logic              i_sample_tick,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [15:0]       i_rec_data,
   input  logic              i_rec_wr,
   input  logic [ADDR_W-1:0] i_play_addr,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_play_start,
   output logic              o_play_pause,
   output logic              o_play_stop,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [15:0]       o_sram_wdata,
   output logic              o_sram_we_n,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic [2:0]        o_state,
   output logic [SEC_W-1:0]  o_seconds
);

   localparam int TICK_W = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SEC_TICKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_REC        = 3'd1,
      ST_REC_PAUSE  = 3'd2,
      ST_PLAY       = 3'd3,
      ST_PLAY_PAUSE = 3'd4
   } state_t;

   state_t              state_q;
   logic                recStart_q;
   logic                recPause_q;
   logic                recStop_q;
   logic                playStart_q;
   logic                playPause_q;
   logic                playStop_q;
   logic [ADDR_W-1:0]   endAddr_q;
   logic [SEC_W-1:0]    seconds_q;
   logic [SEC_W-1:0]    seconds_d;
   logic [TICK_W-1:0]   tickCount_q;
   logic [TICK_W-1:0]   tickCount_d;
`ifdef LOOP_PLAY_EN
   logic                loopPending_q;
`endif

   logic keyStop;
   logic keyPause;
   logic keyStart;
   logic recFull;
   logic playEnd;
   logic counting;
   logic secWrap;

   // Key priority: stop beats pause beats start. Lower-priority keys that
   // arrive in the same cycle are dropped.
   assign keyStop  = i_key_stop;
   assign keyPause = i_key_pause & ~i_key_stop;
   assign keyStart = i_key_start & ~i_key_pause & ~i_key_stop;

   // A write that lands on the last address fills memory and ends the take.
   assign recFull  = i_rec_wr & (i_rec_addr == ADDR_MAX);
   assign playEnd  = (i_play_addr >= endAddr_q);

   // Elapsed time only advances while audio is actually moving.
   // Paused and idle states freeze both counters.
   assign counting = (state_q == ST_REC) || (state_q == ST_PLAY);
   assign secWrap  = counting & i_sample_tick & (tickCount_q == TICK_LAST);

   // Free-running seconds arithmetic. The FSM below overrides it whenever
   // a session start or loop restart needs the counters cleared.
   always_comb begin
      tickCount_d = tickCount_q;
      seconds_d   = seconds_q;
      if (counting && i_sample_tick) begin
         if (secWrap) begin
            tickCount_d = '0;
            if (seconds_q != {SEC_W{1'b1}}) begin
               seconds_d = seconds_q + SEC_W'(1);
            end
         end else begin
            tickCount_d = tickCount_q + TICK_W'(1);
         end
      end
   end

   // Transport FSM. All control pulses are registered, so each one appears
   // for exactly one cycle, in the cycle after the key that caused it.
   // Reset clears the pulses directly, so an abort never emits a stop pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         recStart_q    <= 1'b0;
         recPause_q    <= 1'b0;
         recStop_q     <= 1'b0;
         playStart_q   <= 1'b0;
         playPause_q   <= 1'b0;
         playStop_q    <= 1'b0;
         endAddr_q     <= '0;
         seconds_q     <= '0;
         tickCount_q   <= '0;
`ifdef LOOP_PLAY_EN
         loopPending_q <= 1'b0;
`endif
      end else begin
         recStart_q  <= 1'b0;
         recPause_q  <= 1'b0;
         recStop_q   <= 1'b0;
         playStart_q <= 1'b0;
         playPause_q <= 1'b0;
         playStop_q  <= 1'b0;
         seconds_q   <= seconds_d;
         tickCount_q <= tickCount_d;

         case (state_q)
            ST_IDLE: begin
               if (keyStart) begin
                  if (!i_mode) begin
                     state_q     <= ST_REC;
                     recStart_q  <= 1'b1;
                     seconds_q   <= '0;
                     tickCount_q <= '0;
                  end else if (endAddr_q != '0) begin
                     // Playback only makes sense once something was recorded.
                     state_q     <= ST_PLAY;
                     playStart_q <= 1'b1;
                     seconds_q   <= '0;
                  end
               end
            end

            ST_REC: begin
               if (recFull) begin
                  // The final write still completes this cycle because the
                  // write enable is driven from the current state.
                  state_q   <= ST_IDLE;
                  recStop_q <= 1'b1;
                  endAddr_q <= ADDR_MAX;
               end else if (keyStop) begin
                  state_q   <= ST_IDLE;
                  recStop_q <= 1'b1;
                  endAddr_q <= i_rec_wr ? (i_rec_addr + ADDR_W'(1)) : i_rec_addr;
               end else if (keyPause) begin
                  state_q    <= ST_REC_PAUSE;
                  recPause_q <= 1'b1;
               end
            end

            ST_REC_PAUSE: begin
               if (keyStop) begin
                  state_q   <= ST_IDLE;
                  recStop_q <= 1'b1;
                  endAddr_q <= i_rec_addr;
               end else if (keyStart) begin
                  state_q    <= ST_REC;
                  recStart_q <= 1'b1;
               end
            end

            ST_PLAY: begin
`ifdef LOOP_PLAY_EN
               // Looping: a stop pulse is followed by a start pulse one cycle
               // later. End-of-data is not re-examined while the restart is
               // pending, because the player has not yet rewound its address.
               if (keyStop) begin
                  state_q       <= ST_IDLE;
                  playStop_q    <= 1'b1;
                  loopPending_q <= 1'b0;
               end else if (loopPending_q) begin
                  playStart_q   <= 1'b1;
                  loopPending_q <= 1'b0;
               end else if (playEnd) begin
                  playStop_q    <= 1'b1;
                  loopPending_q <= 1'b1;
                  seconds_q     <= '0;
               end else if (keyPause) begin
                  state_q     <= ST_PLAY_PAUSE;
                  playPause_q <= 1'b1;
               end
`else
               if (keyStop || playEnd) begin
                  state_q    <= ST_IDLE;
                  playStop_q <= 1'b1;
               end else if (keyPause) begin
                  state_q     <= ST_PLAY_PAUSE;
                  playPause_q <= 1'b1;
               end
`endif
            end

            ST_PLAY_PAUSE: begin
               if (keyStop) begin
                  state_q    <= ST_IDLE;
                  playStop_q <= 1'b1;
               end else if (keyStart) begin
                  state_q     <= ST_PLAY;
                  playStart_q <= 1'b1;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // SRAM ownership follows the registered state. Only an active recording
   // may write, so stray recorder strobes in any other state are harmless.
   always_comb begin
      o_sram_addr = '0;
      case (state_q)
         ST_REC, ST_REC_PAUSE:   o_sram_addr = i_rec_addr;
         ST_PLAY, ST_PLAY_PAUSE: o_sram_addr = i_play_addr;
         default:                o_sram_addr = '0;
      endcase
   end

   assign o_sram_we_n  = ~((state_q == ST_REC) & i_rec_wr);
   assign o_sram_wdata = i_rec_data;

   assign o_rec_start  = recStart_q;
   assign o_rec_pause  = recPause_q;
   assign o_rec_stop   = recStop_q;
   assign o_play_start = playStart_q;
   assign o_play_pause = playPause_q;
   assign o_play_stop  = playStop_q;
   assign o_end_addr   = endAddr_q;
   assign o_state      = state_q;
   assign o_seconds    = seconds_q;

endmodule

// File: tb/tb_aud_transport_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aud_transport_ctrl
//
// Directed bench for aud_transport_ctrl. It uses a narrow address space and
// a short second so that the auto-stop and saturation corners fit into a
// few hundred cycles. Inputs change 1 ns after each rising edge. Outputs
// are sampled in that same window.
// ---------------------------------------------------------------------------
module tb_aud_transport_ctrl;

   localparam int              ADDR_W    = 8;
   localparam logic [ADDR_W-1:0] ADDR_MAX = 8'd120;
   localparam int              SEC_TICKS = 4;
   localparam int              SEC_W     = 3;

   logic              i_clk;
   logic              i_rst;
   logic              i_key_start;
   logic              i_key_pause;
   logic              i_key_stop;
   logic              i_mode;
   logic              i_sample_tick;
   logic [ADDR_W-1:0] i_rec_addr;
   logic [15:0]       i_rec_data;
   logic              i_rec_wr;
   logic [ADDR_W-1:0] i_play_addr;
   logic              o_rec_start;
   logic              o_rec_pause;
   logic              o_rec_stop;
   logic              o_play_start;
   logic              o_play_pause;
   logic              o_play_stop;
   logic [ADDR_W-1:0] o_sram_addr;
   logic [15:0]       o_sram_wdata;
   logic              o_sram_we_n;
   logic [ADDR_W-1:0] o_end_addr;
   logic [2:0]        o_state;
   logic [SEC_W-1:0]  o_seconds;

   int testsRun;
   int testsFailed;

   aud_transport_ctrl #(
      .ADDR_W    (ADDR_W),
      .ADDR_MAX  (ADDR_MAX),
      .SEC_TICKS (SEC_TICKS),
      .SEC_W     (SEC_W)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_key_start   (i_key_start),
      .i_key_pause   (i_key_pause),
      .i_key_stop    (i_key_stop),
      .i_mode        (i_mode),
      .i_sample_tick (i_sample_tick),
      .i_rec_addr    (i_rec_addr),
      .i_rec_data    (i_rec_data),
      .i_rec_wr      (i_rec_wr),
      .i_play_addr   (i_play_addr),
      .o_rec_start   (o_rec_start),
      .o_rec_pause   (o_rec_pause),
      .o_rec_stop    (o_rec_stop),
      .o_play_start  (o_play_start),
      .o_play_pause  (o_play_pause),
      .o_play_stop   (o_play_stop),
      .o_sram_addr   (o_sram_addr),
      .o_sram_wdata  (o_sram_wdata),
      .o_sram_we_n   (o_sram_we_n),
      .o_end_addr    (o_end_addr),
      .o_state       (o_state),
      .o_seconds     (o_seconds)
   );

   // 10 ns free-running clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Advance one clock and land 1 ns past the rising edge
   task automatic waitCycle();
      @(posedge i_clk);
      #1;
   endtask

   // One-cycle key pulse; returns just after the edge that consumed it
   task automatic pressKeys(input logic s, input logic p, input logic t);
      i_key_start = s;
      i_key_pause = p;
      i_key_stop  = t;
      waitCycle();
      i_key_start = 1'b0;
      i_key_pause = 1'b0;
      i_key_stop  = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_key_start = 0; i_key_pause = 0; i_key_stop = 0;
      i_mode = 0; i_sample_tick = 0; i_rec_addr = '0; i_rec_data = 16'h0;
      i_rec_wr = 0; i_play_addr = '0;
      waitCycle(); waitCycle();
      i_rst = 1'b0;
      testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_state got %0d want 0", o_state); end
      testsRun++; if (o_sram_we_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_we_n got %0b want 1", o_sram_we_n); end
      testsRun++; if (o_end_addr !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_end_addr got %0d want 0", o_end_addr); end
      testsRun++; if (o_sram_addr !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_sram_addr got %0d want 0", o_sram_addr); end
      testsRun++; if (o_seconds !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_seconds got %0d want 0", o_seconds); end
      testsRun++;
      if ({o_rec_start, o_rec_pause, o_rec_stop, o_play_start, o_play_pause, o_play_stop} !== 6'b0) begin
         testsFailed++; $display("[TB] FAIL reset_pulses got %b want 000000",
            {o_rec_start, o_rec_pause, o_rec_stop, o_play_start, o_play_pause, o_play_stop});
      end
      // Abort a recording with reset
      i_mode = 0;
      pressKeys(1, 0, 0);
      testsRun++; if (o_state !== 3'd1) begin testsFailed++; $display("[TB] FAIL abort_rec_entry got %0d want 1", o_state); end
      i_rec_addr = 8'd100;
      #1;
      testsRun++; if (o_sram_addr !== 8'd100) begin testsFailed++; $display("[TB] FAIL abort_sram_addr got %0d want 100", o_sram_addr); end
      i_rst = 1'b1;
      waitCycle();
      i_rst = 1'b0;
      testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL abort_state got %0d want 0", o_state); end
      testsRun++; if (o_end_addr !== 8'd0) begin testsFailed++; $display("[TB] FAIL abort_end_addr got %0d want 0", o_end_addr); end
      testsRun++; if (o_rec_stop !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_rec_stop got %0b want 0", o_rec_stop); end
      waitCycle();
      testsRun++; if (o_rec_stop !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_rec_stop_late got %0b want 0", o_rec_stop); end
      i_rec_addr = '0;
   endtask

   task automatic test_record_stop();
      int weLow;
      weLow = 0;
      i_mode = 0;
      pressKeys(1, 0, 0);
      testsRun++; if (o_rec_start !== 1'b1) begin testsFailed++; $display("[TB] FAIL rec_start_pulse got %0b want 1", o_rec_start); end
      for (int i = 0; i < 50; i++) begin
         i_rec_addr = 8'(i);
         i_rec_data = 16'(16'hA500 + i);
         i_rec_wr   = 1'b1;
         #1;
         if (o_sram_we_n === 1'b0) weLow++;
         waitCycle();
         if (i == 0) begin
            testsRun++; if (o_rec_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL rec_start_width got %0b want 0", o_rec_start); end
         end
      end
      i_rec_wr   = 1'b0;
      i_rec_addr = 8'd50;
      i_key_stop = 1'b1;
      #1;
      if (o_sram_we_n === 1'b0) weLow++;
      waitCycle();
      i_key_stop = 1'b0;
      testsRun++; if (weLow !== 50) begin testsFailed++; $display("[TB] FAIL rec_write_cycles got %0d want 50", weLow); end
      testsRun++; if (o_rec_stop !== 1'b1) begin testsFailed++; $display("[TB] FAIL rec_stop_pulse got %0b want 1", o_rec_stop); end
      testsRun++; if (o_end_addr !== 8'd50) begin testsFailed++; $display("[TB] FAIL rec_end_addr got %0d want 50", o_end_addr); end
      testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL rec_stop_state got %0d want 0", o_state); end
      waitCycle();
      testsRun++; if (o_rec_stop !== 1'b0) begin testsFailed++; $display("[TB] FAIL rec_stop_width got %0b want 0", o_rec_stop); end
   endtask

   task automatic test_key_priority();
      i_mode = 0;
      pressKeys(1, 0, 0);
      i_rec_addr = 8'd10;
      waitCycle();
      pressKeys(1, 1, 1);
      testsRun++; if (o_rec_stop !== 1'b1) begin testsFailed++; $display("[TB] FAIL prio_stop got %0b want 1", o_rec_stop); end
      testsRun++;
      if ({o_rec_start, o_rec_pause} !== 2'b00) begin
         testsFailed++; $display("[TB] FAIL prio_dropped got %b want 00", {o_rec_start, o_rec_pause});
      end
      testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL prio_state got %0d want 0", o_state); end
      testsRun++; if (o_end_addr !== 8'd10) begin testsFailed++; $display("[TB] FAIL prio_end_addr got %0d want 10", o_end_addr); end
   endtask

   task automatic test_seconds();
      i_mode = 0;
      i_rec_addr = 8'd0;
      pressKeys(1, 0, 0);
      testsRun++; if (o_seconds !== 3'd0) begin testsFailed++; $display("[TB] FAIL sec_cleared got %0d want 0", o_seconds); end
      i_sample_tick = 1'b1;
      repeat (9) waitCycle();
      i_sample_tick = 1'b0;
      testsRun++; if (o_seconds !== 3'd2) begin testsFailed++; $display("[TB] FAIL sec_after9 got %0d want 2", o_seconds); end
      pressKeys(0, 1, 0);
      testsRun++; if (o_rec_pause !== 1'b1) begin testsFailed++; $display("[TB] FAIL sec_pause_pulse got %0b want 1", o_rec_pause); end
      testsRun++; if (o_state !== 3'd2) begin testsFailed++; $display("[TB] FAIL sec_pause_state got %0d want 2", o_state); end
      i_rec_wr = 1'b1;
      #1;
      testsRun++; if (o_sram_we_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL pause_we_n got %0b want 1", o_sram_we_n); end
      i_rec_wr = 1'b0;
      i_sample_tick = 1'b1;
      repeat (4) waitCycle();
      i_sample_tick = 1'b0;
      testsRun++; if (o_seconds !== 3'd2) begin testsFailed++; $display("[TB] FAIL sec_frozen got %0d want 2", o_seconds); end
      pressKeys(1, 0, 0);
      testsRun++; if (o_state !== 3'd1) begin testsFailed++; $display("[TB] FAIL sec_resume_state got %0d want 1", o_state); end
      i_sample_tick = 1'b1;
      repeat (3) waitCycle();
      i_sample_tick = 1'b0;
      testsRun++; if (o_seconds !== 3'd3) begin testsFailed++; $display("[TB] FAIL sec_final got %0d want 3", o_seconds); end
      pressKeys(0, 0, 1);
      i_sample_tick = 1'b1;
      repeat (8) waitCycle();
      i_sample_tick = 1'b0;
      testsRun++; if (o_seconds !== 3'd3) begin testsFailed++; $display("[TB] FAIL sec_idle_hold got %0d want 3", o_seconds); end
   endtask

   task automatic test_addr_max();
      int writes;
      writes = 0;
      i_mode = 0;
      pressKeys(1, 0, 0);
      for (int a = 115; a <= 121; a++) begin
         i_rec_addr = 8'(a);
         i_rec_wr   = 1'b1;
         #1;
         if (o_sram_we_n === 1'b0) writes++;
         waitCycle();
         if (a == 120) begin
            testsRun++; if (o_rec_stop !== 1'b1) begin testsFailed++; $display("[TB] FAIL max_auto_stop got %0b want 1", o_rec_stop); end
            testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL max_state got %0d want 0", o_state); end
            testsRun++; if (o_end_addr !== ADDR_MAX) begin testsFailed++; $display("[TB] FAIL max_end_addr got %0d want %0d", o_end_addr, ADDR_MAX); end
         end
      end
      i_rec_wr = 1'b0;
      testsRun++; if (writes !== 6) begin testsFailed++; $display("[TB] FAIL max_write_count got %0d want 6", writes); end
   endtask

   task automatic test_saturate_and_pause_stop();
      i_mode = 0;
      i_rec_addr = 8'd0;
      pressKeys(1, 0, 0);
      i_sample_tick = 1'b1;
      repeat (40) waitCycle();
      i_sample_tick = 1'b0;
      testsRun++; if (o_seconds !== 3'd7) begin testsFailed++; $display("[TB] FAIL sec_saturate got %0d want 7", o_seconds); end
      pressKeys(0, 1, 0);
      i_rec_addr = 8'd50;
      pressKeys(0, 0, 1);
      testsRun++; if (o_rec_stop !== 1'b1) begin testsFailed++; $display("[TB] FAIL pstop_pulse got %0b want 1", o_rec_stop); end
      testsRun++; if (o_end_addr !== 8'd50) begin testsFailed++; $display("[TB] FAIL pstop_end_addr got %0d want 50", o_end_addr); end
      i_rec_addr = 8'd0;
   endtask

   task automatic test_play();
      i_mode = 1;
      i_play_addr = 8'd10;
      pressKeys(1, 0, 0);
      testsRun++; if (o_play_start !== 1'b1) begin testsFailed++; $display("[TB] FAIL play_start_pulse got %0b want 1", o_play_start); end
      testsRun++; if (o_state !== 3'd3) begin testsFailed++; $display("[TB] FAIL play_state got %0d want 3", o_state); end
      testsRun++; if (o_seconds !== 3'd0) begin testsFailed++; $display("[TB] FAIL play_sec_clear got %0d want 0", o_seconds); end
      i_rec_wr = 1'b1;
      i_mode   = 1'b0;
      #1;
      testsRun++; if (o_sram_we_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL play_we_n got %0b want 1", o_sram_we_n); end
      testsRun++; if (o_sram_addr !== 8'd10) begin testsFailed++; $display("[TB] FAIL play_sram_addr got %0d want 10", o_sram_addr); end
      i_sample_tick = 1'b1;
      repeat (5) waitCycle();
      i_sample_tick = 1'b0;
      testsRun++; if (o_seconds !== 3'd1) begin testsFailed++; $display("[TB] FAIL play_seconds got %0d want 1", o_seconds); end
      testsRun++; if (o_state !== 3'd3) begin testsFailed++; $display("[TB] FAIL play_mode_ignored got %0d want 3", o_state); end
      pressKeys(0, 1, 0);
      testsRun++; if (o_state !== 3'd4) begin testsFailed++; $display("[TB] FAIL play_pause_state got %0d want 4", o_state); end
      pressKeys(1, 0, 0);
      testsRun++; if (o_play_start !== 1'b1) begin testsFailed++; $display("[TB] FAIL play_resume_pulse got %0b want 1", o_play_start); end
      // End of data arrives together with a pause key; end of data wins
      i_play_addr = 8'd50;
      pressKeys(0, 1, 0);
      testsRun++; if (o_play_stop !== 1'b1) begin testsFailed++; $display("[TB] FAIL play_end_stop got %0b want 1", o_play_stop); end
      testsRun++; if (o_play_pause !== 1'b0) begin testsFailed++; $display("[TB] FAIL play_end_pause got %0b want 0", o_play_pause); end
`ifdef LOOP_PLAY_EN
      testsRun++; if (o_state !== 3'd3) begin testsFailed++; $display("[TB] FAIL loop_state got %0d want 3", o_state); end
      testsRun++; if (o_seconds !== 3'd0) begin testsFailed++; $display("[TB] FAIL loop_seconds got %0d want 0", o_seconds); end
      i_play_addr = 8'd0;
      waitCycle();
      testsRun++; if (o_play_start !== 1'b1) begin testsFailed++; $display("[TB] FAIL loop_restart got %0b want 1", o_play_start); end
      testsRun++; if (o_play_stop !== 1'b0) begin testsFailed++; $display("[TB] FAIL loop_stop_width got %0b want 0", o_play_stop); end
      pressKeys(0, 0, 1);
      testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL loop_user_stop got %0d want 0", o_state); end
`else
      testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL play_end_state got %0d want 0", o_state); end
      waitCycle();
      testsRun++; if (o_play_stop !== 1'b0) begin testsFailed++; $display("[TB] FAIL play_stop_width got %0b want 0", o_play_stop); end
`endif
      i_rec_wr = 1'b0;
   endtask

   task automatic test_play_empty();
      i_rst = 1'b1;
      waitCycle();
      i_rst = 1'b0;
      i_mode = 1;
      pressKeys(1, 0, 0);
      testsRun++; if (o_state !== 3'd0) begin testsFailed++; $display("[TB] FAIL empty_state got %0d want 0", o_state); end
      testsRun++; if (o_play_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL empty_pulse got %0b want 0", o_play_start); end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      test_reset();
      test_record_stop();
      test_key_priority();
      test_seconds();
      test_addr_max();
      test_saturate_and_pause_stop();
      test_play();
      test_play_empty();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
